// File: rtl/mips_inst_intake.sv
// Instruction intake for a multicycle MIPS core: buffers external words in a
// FIFO and hands exactly one to the core on each visit to its FETCH state.
module mips_inst_intake #(
    parameter int unsigned DEPTH       = 4,
    parameter logic [3:0]  FETCH_STATE = 4'd0,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_inst,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic [3:0]               core_state,
    output logic [31:0]              inst_out,
    output logic                     inst_valid,
    output logic [31:0]              inst_pc,
    output logic [31:0]              fetch_pc,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    typedef enum logic {
        IDLE,
        SERVED
    } state_e;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("mips_inst_intake: DEPTH must be a power of two >= 2");
    end

    logic [31:0] mem_q [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;

    logic        full;
    logic        empty;
    logic        in_fetch;
    logic        push;
    logic        pop;
    logic [31:0] head;

    // Pointers carry one extra bit so full and empty differ at equal index.
    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign in_ready = !full;
    assign in_fetch = (core_state == FETCH_STATE);

    assign push = in_valid && !full && !flush;
    assign pop  = in_fetch && (state_q == IDLE) && !empty && !flush;
    assign head = mem_q[rd_ptr_q[AW-1:0]];

    assign stall = in_fetch && (state_q == IDLE) && empty;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = 1'b0;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = RESET_PC;
            state_d    = IDLE;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + PTR_ONE;
                inst_out_d   = head;
                inst_pc_d    = fetch_pc_q;
                fetch_pc_d   = fetch_pc_q + 32'd4;
                inst_valid_d = 1'b1;
            end
            // One delivery per FETCH visit: re-arm only once the core leaves.
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_d = SERVED;
                    end
                end
                SERVED: begin
                    if (!in_fetch) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            inst_out_q   <= '0;
            inst_pc_q    <= RESET_PC;
            inst_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_inst;
        end
    end

    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign fetch_pc   = fetch_pc_q;

endmodule

// File: tb/tb_mips_inst_intake.sv
// Directed bench for mips_inst_intake: delivery, fill, stall, concurrency,
// flush and asynchronous reset.
module tb_mips_inst_intake;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [3:0]  core_state = 4'd3;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] fetch_pc;
    logic        stall;
    logic [2:0]  level;

    int n_chk = 0;
    int n_ok  = 0;

    mips_inst_intake #(
        .DEPTH(4),
        .FETCH_STATE(4'd0),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_inst(in_inst),
        .in_ready(in_ready),
        .flush(flush),
        .core_state(core_state),
        .inst_out(inst_out),
        .inst_valid(inst_valid),
        .inst_pc(inst_pc),
        .fetch_pc(fetch_pc),
        .stall(stall),
        .level(level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        core_state = 4'd3;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else n_ok++;
        n_chk++; if (level !== 3'd0) $display("FAIL rst_level got %0d exp 0", level); else n_ok++;
        n_chk++; if (inst_out !== 32'h0) $display("FAIL rst_inst_out got %h exp 0", inst_out); else n_ok++;
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid got %b exp 0", inst_valid); else n_ok++;
        n_chk++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc got %h exp 0", inst_pc); else n_ok++;
        n_chk++; if (fetch_pc !== 32'h0) $display("FAIL rst_fetch_pc got %h exp 0", fetch_pc); else n_ok++;
        n_chk++; if (stall !== 1'b0) $display("FAIL rst_stall_nofetch got %b exp 0", stall); else n_ok++;
        core_state = 4'd0;
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL rst_stall_fetch got %b exp 1", stall); else n_ok++;
        core_state = 4'd3;
        step();
        rst = 1'b1;
    endtask

    task automatic test_basic;
        int nv;
        logic [31:0] got_inst;
        logic [31:0] got_pc;
        nv = 0;
        got_inst = '0;
        got_pc = 32'hFFFF_FFFF;
        apply_reset();
        in_valid = 1'b1;
        in_inst = 32'h2008_0005;
        step();
        in_valid = 1'b0;
        n_chk++; if (level !== 3'd1) $display("FAIL basic_level got %0d exp 1", level); else n_ok++;
        core_state = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (inst_valid === 1'b1) begin
                nv++;
                got_inst = inst_out;
                got_pc = inst_pc;
            end
        end
        core_state = 4'd3;
        n_chk++; if (nv != 1) $display("FAIL basic_pulses got %0d exp 1", nv); else n_ok++;
        n_chk++; if (got_inst !== 32'h2008_0005) $display("FAIL basic_inst got %h exp 20080005", got_inst); else n_ok++;
        n_chk++; if (got_pc !== 32'h0) $display("FAIL basic_pc got %h exp 0", got_pc); else n_ok++;
        n_chk++; if (fetch_pc !== 32'h4) $display("FAIL basic_fetch_pc got %h exp 4", fetch_pc); else n_ok++;
        step();
    endtask

    task automatic test_fill;
        logic [31:0] fw [5];
        fw[0] = 32'h1111_0001;
        fw[1] = 32'h2222_0002;
        fw[2] = 32'h3333_0003;
        fw[3] = 32'h4444_0004;
        fw[4] = 32'h5555_0005;
        apply_reset();
        core_state = 4'd3;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_inst = fw[i];
            step();
            if (i == 2) begin
                n_chk++; if (in_ready !== 1'b1) $display("FAIL fill_ready3 got %b exp 1", in_ready); else n_ok++;
            end
            if (i == 3) begin
                n_chk++; if (in_ready !== 1'b0) $display("FAIL fill_ready4 got %b exp 0", in_ready); else n_ok++;
                n_chk++; if (level !== 3'd4) $display("FAIL fill_level4 got %0d exp 4", level); else n_ok++;
            end
        end
        in_valid = 1'b0;
        n_chk++; if (level !== 3'd4) $display("FAIL fill_level5 got %0d exp 4", level); else n_ok++;
        for (int k = 0; k < 4; k++) begin
            core_state = 4'd0;
            step();
            n_chk++; if (inst_valid !== 1'b1) $display("FAIL fill_valid%0d got %b exp 1", k, inst_valid); else n_ok++;
            n_chk++; if (inst_out !== fw[k]) $display("FAIL fill_inst%0d got %h exp %h", k, inst_out, fw[k]); else n_ok++;
            n_chk++; if (inst_pc !== 32'(4 * k)) $display("FAIL fill_pc%0d got %h exp %h", k, inst_pc, 32'(4 * k)); else n_ok++;
            core_state = 4'd3;
            step();
            n_chk++; if (inst_valid !== 1'b0) $display("FAIL fill_pulse%0d got %b exp 0", k, inst_valid); else n_ok++;
        end
        n_chk++; if (level !== 3'd0) $display("FAIL fill_drained got %0d exp 0", level); else n_ok++;
        core_state = 4'd0;
        step();
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL fill_empty_valid got %b exp 0", inst_valid); else n_ok++;
        n_chk++; if (stall !== 1'b1) $display("FAIL fill_empty_stall got %b exp 1", stall); else n_ok++;
        core_state = 4'd3;
        step();
    endtask

    task automatic test_stall;
        apply_reset();
        core_state = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (stall !== 1'b1) $display("FAIL stall_wait%0d got %b exp 1", i, stall); else n_ok++;
        end
        in_valid = 1'b1;
        in_inst = 32'h8C08_0010;
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL stall_cycleN got %b exp 1", stall); else n_ok++;
        step();
        in_valid = 1'b0;
        n_chk++; if (stall !== 1'b0) $display("FAIL stall_N1 got %b exp 0", stall); else n_ok++;
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL stall_N1_valid got %b exp 0", inst_valid); else n_ok++;
        step();
        n_chk++; if (inst_valid !== 1'b1) $display("FAIL stall_N2_valid got %b exp 1", inst_valid); else n_ok++;
        n_chk++; if (inst_out !== 32'h8C08_0010) $display("FAIL stall_N2_inst got %h exp 8c080010", inst_out); else n_ok++;
        n_chk++; if (stall !== 1'b0) $display("FAIL stall_N2 got %b exp 0", stall); else n_ok++;
        core_state = 4'd3;
        step();
    endtask

    task automatic test_concurrency;
        logic [31:0] exp_q [$];
        logic [31:0] ew;
        logic [31:0] w;
        apply_reset();
        core_state = 4'd3;
        in_valid = 1'b1;
        in_inst = 32'hAAAA_0000;
        step();
        exp_q.push_back(32'hAAAA_0000);
        in_inst = 32'hBBBB_0000;
        step();
        exp_q.push_back(32'hBBBB_0000);
        n_chk++; if (level !== 3'd2) $display("FAIL conc_level_pre got %0d exp 2", level); else n_ok++;
        in_inst = 32'hCCCC_0000;
        core_state = 4'd0;
        step();
        ew = exp_q.pop_front();
        exp_q.push_back(32'hCCCC_0000);
        n_chk++; if (level !== 3'd2) $display("FAIL conc_level_same got %0d exp 2", level); else n_ok++;
        n_chk++; if (inst_out !== ew) $display("FAIL conc_first got %h exp %h", inst_out, ew); else n_ok++;
        in_valid = 1'b0;
        core_state = 4'd3;
        step();
        for (int i = 0; i < 10; i++) begin
            w = 32'hC0DE_0000 + 32'(i);
            in_valid = 1'b1;
            in_inst = w;
            core_state = 4'd0;
            step();
            ew = exp_q.pop_front();
            exp_q.push_back(w);
            n_chk++; if (inst_out !== ew) $display("FAIL conc_inst%0d got %h exp %h", i, inst_out, ew); else n_ok++;
            n_chk++; if (inst_pc !== 32'(4 * (i + 1))) $display("FAIL conc_pc%0d got %h exp %h", i, inst_pc, 32'(4 * (i + 1))); else n_ok++;
            n_chk++; if (level !== 3'd2) $display("FAIL conc_level%0d got %0d exp 2", i, level); else n_ok++;
            in_valid = 1'b0;
            core_state = 4'd3;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            core_state = 4'd0;
            step();
            ew = exp_q.pop_front();
            n_chk++; if (inst_out !== ew) $display("FAIL conc_drain%0d got %h exp %h", i, inst_out, ew); else n_ok++;
            core_state = 4'd3;
            step();
        end
        n_chk++; if (level !== 3'd0) $display("FAIL conc_end_level got %0d exp 0", level); else n_ok++;
    endtask

    task automatic test_flush;
        apply_reset();
        core_state = 4'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_inst = 32'hF000_0000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            core_state = 4'd0;
            step();
            core_state = 4'd3;
            step();
        end
        in_valid = 1'b1;
        in_inst = 32'hF000_0004;
        step();
        n_chk++; if (level !== 3'd3) $display("FAIL flush_pre_level got %0d exp 3", level); else n_ok++;
        n_chk++; if (fetch_pc !== 32'h8) $display("FAIL flush_pre_pc got %h exp 8", fetch_pc); else n_ok++;
        flush = 1'b1;
        in_inst = 32'hDEAD_BEEF;
        core_state = 4'd0;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        n_chk++; if (level !== 3'd0) $display("FAIL flush_level got %0d exp 0", level); else n_ok++;
        n_chk++; if (fetch_pc !== 32'h0) $display("FAIL flush_fetch_pc got %h exp 0", fetch_pc); else n_ok++;
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", inst_valid); else n_ok++;
        n_chk++; if (inst_out !== 32'hF000_0001) $display("FAIL flush_hold_inst got %h exp f0000001", inst_out); else n_ok++;
        n_chk++; if (inst_pc !== 32'h4) $display("FAIL flush_hold_pc got %h exp 4", inst_pc); else n_ok++;
        step();
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL flush_nostore got %b exp 0", inst_valid); else n_ok++;
        n_chk++; if (stall !== 1'b1) $display("FAIL flush_stall got %b exp 1", stall); else n_ok++;
        core_state = 4'd3;
        step();

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_inst = 32'hE000_0000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        core_state = 4'd0;
        step();
        n_chk++; if (inst_out !== 32'hE000_0000) $display("FAIL rstmid_pre_inst got %h exp e0000000", inst_out); else n_ok++;
        core_state = 4'd3;
        step();
        core_state = 4'd0;
        #3;
        rst = 1'b0;
        #1;
        n_chk++; if (level !== 3'd0) $display("FAIL rstmid_level got %0d exp 0", level); else n_ok++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", in_ready); else n_ok++;
        n_chk++; if (inst_out !== 32'h0) $display("FAIL rstmid_inst got %h exp 0", inst_out); else n_ok++;
        n_chk++; if (inst_pc !== 32'h0) $display("FAIL rstmid_inst_pc got %h exp 0", inst_pc); else n_ok++;
        n_chk++; if (fetch_pc !== 32'h0) $display("FAIL rstmid_fetch_pc got %h exp 0", fetch_pc); else n_ok++;
        n_chk++; if (stall !== 1'b1) $display("FAIL rstmid_stall got %b exp 1", stall); else n_ok++;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++; if (inst_valid !== 1'b0) $display("FAIL rstmid_valid%0d got %b exp 0", i, inst_valid); else n_ok++;
        end
        core_state = 4'd3;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_stall();
        test_concurrency();
        test_flush();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
